seq_101_de: RTL and testbench
=============================

// Module: seq_101_de
// PURPOSE
// - Serial "101" sequence detector: a Moore FSM that samples one bit of din per clk rising edge.
// - Raises dout for exactly one clock after the bit pattern 1-0-1 has been received.
// - Leaf control block for serial-stream monitoring. Overlapping matches are counted by default.
// PARAMETERS
// - OVERLAP  1  1: the trailing '1' of a match may start the next match; 0: matching restarts after each hit
// PORTS (declaration order must be din, clk, rst, dout for positional instantiation)
// - clk   input   1  system clock; all state changes on the rising edge
// - rst   input   1  synchronous reset, active-high, sampled on the clk rising edge
// - din   input   1  serial data bit, sampled on each clk rising edge
// - dout  output  1  match flag; 1 while the FSM is in state S101
// BEHAVIOUR
// - One clock. Reset is synchronous and active-high. No asynchronous paths.
// - Reset: on a rising edge with rst=1, state <= S0 and dout=0; rst has priority over din.
// - Reset mid-sequence discards any partial match. The first din is sampled on the first edge with rst=0.
// - States (2-bit): S0 = idle/no progress, S1 = seen "1", S10 = seen "10", S101 = match.
// - Transitions on din=0 / din=1:
//   - S0:   0 -> S0,  1 -> S1
//   - S1:   0 -> S10, 1 -> S1
//   - S10:  0 -> S0,  1 -> S101
//   - S101, OVERLAP=1: 0 -> S10, 1 -> S1
//   - S101, OVERLAP=0: 0 -> S0,  1 -> S1
// - Output: dout = (state == S101), decoded from the state register only (Moore), so it is glitch-free w.r.t. din.
// - Latency: dout rises in the cycle after the rising edge that samples the final '1'.
//   dout is high for exactly one clock per match.
// - dout can never be high in two consecutive cycles (S101 always exits).
// - Illegal or uninitialised state encodings go to S0 on the next edge (default branch). dout=0 in those states.
// - Before the first reset edge, state is undefined; benches must reset first.
// STRUCTURE
// - Shared package: state encoding constants S0=2'b00, S1=2'b01, S10=2'b10, S101=2'b11.
// - Single module. Split into a registered state process, a combinational next-state process and a combinational output decode.
// - No sub-module.
// TESTING (drive din and rst on the clk falling edge; 10-unit clock period; check dout after the rising edge)
// - Reset: hold rst=1 for 2 edges with din=0, then release.
//   -> dout=0, state=S0.
// - Basic match: din 1,0,1.
//   -> dout=1 for exactly one cycle after the 3rd sampling edge; 0 at all other times.
// - Overlap (OVERLAP=1): din 1,0,1,0,1,1,0,1.
//   -> dout pulses after bits 3, 5 and 8 (3 pulses).
// - Non-overlap (OVERLAP=0): same din stream.
//   -> dout pulses after bits 3 and 8 only (2 pulses).
// - Near misses: din 1,1,0,0,1,0,0.
//   -> dout stays 0 throughout.
// - Mid-sequence reset: din 1,0, then rst=1 for one edge, then din 1.
//   -> no pulse; the FSM returns to S0 and then S1.

Source files
------------

// File: rtl/seq_101_de_pkg.sv
// seq_101_de_pkg: state encoding shared by the 101 sequence detector
package seq_101_de_pkg;
    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_e;
endpackage

// File: rtl/seq_101_de.sv
// seq_101_de: Moore detector pulsing dout for one clock after serial bits 1-0-1
module seq_101_de
    import seq_101_de_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic din,
    input  logic clk,
    input  logic rst,
    output logic dout
);
    state_e state_q, state_d;
    always_ff @(posedge clk) begin
        state_q <= rst ? S0 : state_d;
    end
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S10;
            S10:     state_d = din ? S101 : S0;
            S101:    state_d = din ? S1 : (OVERLAP ? S10 : S0);
            default: state_d = S0;
        endcase
    end
    always_comb begin
        dout = (state_q == S101);
    end
endmodule

// File: tb/tb_seq_101_de.sv
// tb_seq_101_de: table-driven check of overlapping and non-overlapping 101 detectors
module tb_seq_101_de;
    typedef struct {
        logic rst;
        logic din;
        logic exp_ov;
        logic exp_no;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout_ov, dout_no;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    seq_101_de #(.OVERLAP(1'b1)) u_ov (.din(din), .clk(clk), .rst(rst), .dout(dout_ov));
    seq_101_de #(.OVERLAP(1'b0)) u_no (.din(din), .clk(clk), .rst(rst), .dout(dout_no));
    always #5 clk = ~clk;
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask
    task automatic add(input logic r, input logic d, input logic eo, input logic en);
        vec_t v;
        v.rst = r;
        v.din = d;
        v.exp_ov = eo;
        v.exp_no = en;
        vecs.push_back(v);
    endtask
    initial begin
        int pulses_ov, pulses_no, consec;
        logic prev_ov, prev_no;
        add(1, 0, 0, 0); add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 1, 1);
        add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 1, 1); add(0, 0, 0, 0);
        add(0, 1, 1, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 1, 1);
        add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(1, 0, 0, 0); add(0, 1, 0, 0);
        add(0, 0, 0, 0); add(0, 1, 1, 1);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].din);
            check($sformatf("vec%0d_ov", i), dout_ov, vecs[i].exp_ov);
            check($sformatf("vec%0d_no", i), dout_no, vecs[i].exp_no);
        end
        // reset must win over a din=1 that would otherwise complete a match
        step(1, 0);
        step(0, 1);
        step(0, 0);
        step(1, 1);
        check("rst_prio_ov", dout_ov, 1'b0);
        check("rst_prio_no", dout_no, 1'b0);
        step(0, 0);
        check("after_rst_ov", dout_ov, 1'b0);
        check("after_rst_no", dout_no, 1'b0);
        pulses_ov = 0;
        pulses_no = 0;
        consec = 0;
        prev_ov = 1'b0;
        prev_no = 1'b0;
        step(1, 0);
        foreach (vecs[i]) begin
            if (i >= 6 && i <= 13) begin
                step(0, vecs[i].din);
                pulses_ov += int'(dout_ov);
                pulses_no += int'(dout_no);
                consec += int'(dout_ov & prev_ov) + int'(dout_no & prev_no);
                prev_ov = dout_ov;
                prev_no = dout_no;
            end
        end
        checks++;
        if (pulses_ov != 3) begin
            errors++;
            $display("FAIL pulses_ov: got %0d expected 3", pulses_ov);
        end
        checks++;
        if (pulses_no != 2) begin
            errors++;
            $display("FAIL pulses_no: got %0d expected 2", pulses_no);
        end
        checks++;
        if (consec != 0) begin
            errors++;
            $display("FAIL consecutive_high: got %0d expected 0", consec);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
